// File: rtl/gen_skid_buf_pkg.sv
// Shared types and constants for the skid buffer and its storage flops.
package gen_skid_buf_pkg;

  localparam int unsigned ZeroWordW = 1024;
  localparam logic [ZeroWordW-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    SkidEmpty = 2'b00,
    SkidBusy  = 2'b01,
    SkidFull  = 2'b10
  } skid_state_e;

  // Occupancy reported for each buffer state.
  function automatic logic [1:0] state_count(input skid_state_e s);
    logic [1:0] cnt;
    cnt = 2'd0;
    case (s)
      SkidBusy: cnt = 2'd1;
      SkidFull: cnt = 2'd2;
      default:  cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/gen_dffs.sv
// Load-enabled register bank with synchronous active-low clear to zero.
module gen_dffs
  import gen_skid_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= WIDTH'(ZeroWord);
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/gen_skid_buf.sv
// Two-entry skid buffer: main register drives downstream, skid register absorbs
// the one beat accepted while downstream stalls, so s_ready_o never sees m_ready_i.
module gen_skid_buf
  import gen_skid_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             s_valid_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic [1:0]       count_o
);

  skid_state_e      state_d;
  skid_state_e      state_q;
  logic             main_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic             skid_en;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // All handshake outputs decode the state register only.
  assign s_ready_o = (state_q != SkidFull);
  assign m_valid_o = (state_q != SkidEmpty);
  assign m_data_o  = main_q;
  assign count_o   = state_count(state_q);

  assign in_fire  = s_valid_i & s_ready_o;
  assign out_fire = m_valid_o & m_ready_i;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = s_data_i;
    skid_en = 1'b0;
    if (flush_i) begin
      // Flush empties the buffer but leaves the data registers untouched.
      state_d = SkidEmpty;
    end else begin
      case (state_q)
        SkidEmpty: begin
          if (in_fire) begin
            main_en = 1'b1;
            state_d = SkidBusy;
          end
        end
        SkidBusy: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
            state_d = SkidFull;
          end else if (out_fire) begin
            state_d = SkidEmpty;
          end
        end
        SkidFull: begin
          if (out_fire) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = SkidBusy;
          end
        end
        default: state_d = SkidEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SkidEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  gen_dffs #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  gen_dffs #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (skid_en),
    .d_i   (s_data_i),
    .q_o   (skid_q)
  );

endmodule

// File: tb/tb_gen_skid_buf.sv
// Self-checking bench for gen_skid_buf: directed scenarios plus a random soak,
// with a scoreboard queue filled on accept and drained on output handshake.
module tb_gen_skid_buf;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic             s_valid_i;
  logic [WIDTH-1:0] s_data_i;
  logic             s_ready_o;
  logic             m_valid_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_ready_i;
  logic [1:0]       count_o;

  int dir_checks = 0;
  int dir_errors = 0;
  int mon_checks = 0;
  int mon_errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  gen_skid_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_ready_o (s_ready_o),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_ready_i (m_ready_i),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    dir_checks++;
    if (act !== exp) begin
      dir_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp;
    if (!rst_n || flush_i) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        mon_checks++;
        if (!m_valid_o || m_data_o !== prev_data) begin
          mon_errors++;
          $display("FAIL stall_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                   m_valid_o, m_data_o, prev_data);
        end
      end
      if (m_valid_o && m_ready_i) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          mon_errors++;
          $display("FAIL sb_unexpected: got %0h expected no output", m_data_o);
        end else begin
          exp = exp_q.pop_front();
          if (m_data_o !== exp) begin
            mon_errors++;
            $display("FAIL sb_data: got %0h expected %0h", m_data_o, exp);
          end
        end
      end
      if (s_valid_i && s_ready_o) exp_q.push_back(s_data_i);
      prev_hold = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
    end
  end

  task automatic fill_ab();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'hA;
    step();
    s_data_i  = 32'hB;
    step();
    s_valid_i = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'hDEAD_BEEF;
    m_ready_i = 1'b0;
    step();
    step();
    check("rst_m_valid", WIDTH'(m_valid_o), 32'd0);
    check("rst_m_data",  m_data_o, 32'd0);
    check("rst_s_ready", WIDTH'(s_ready_o), 32'd1);
    check("rst_count",   WIDTH'(count_o), 32'd0);

    // Streaming 1..8 back-to-back.
    rst_n     = 1'b1;
    s_valid_i = 1'b0;
    step();
    m_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = WIDTH'(i);
      step();
      check("stream_valid", WIDTH'(m_valid_o), 32'd1);
      check("stream_data",  m_data_o, WIDTH'(i));
      check("stream_count", WIDTH'(count_o), 32'd1);
    end
    s_valid_i = 1'b0;
    step();
    check("stream_end_count", WIDTH'(count_o), 32'd0);

    // Backpressure.
    fill_ab();
    check("bp_count",   WIDTH'(count_o), 32'd2);
    check("bp_s_ready", WIDTH'(s_ready_o), 32'd0);
    check("bp_data",    m_data_o, 32'hA);
    step();
    check("bp_hold",    m_data_o, 32'hA);
    m_ready_i = 1'b1;
    step();
    check("bp_drain_ready", WIDTH'(s_ready_o), 32'd1);
    check("bp_drain_data",  m_data_o, 32'hB);
    check("bp_drain_count", WIDTH'(count_o), 32'd1);
    step();
    check("bp_empty_count", WIDTH'(count_o), 32'd0);

    // Flush while full, with a competing input.
    fill_ab();
    flush_i   = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 32'hC;
    step();
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    check("flush_valid",   WIDTH'(m_valid_o), 32'd0);
    check("flush_count",   WIDTH'(count_o), 32'd0);
    check("flush_s_ready", WIDTH'(s_ready_o), 32'd1);
    m_ready_i = 1'b1;
    step();
    check("flush_no_c", WIDTH'(m_valid_o), 32'd0);

    // Reset while full.
    fill_ab();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_count", WIDTH'(count_o), 32'd0);
    check("mrst_data",  m_data_o, 32'd0);
    check("mrst_valid", WIDTH'(m_valid_o), 32'd0);
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 32'hD;
    step();
    s_valid_i = 1'b0;
    check("mrst_d_valid", WIDTH'(m_valid_o), 32'd1);
    check("mrst_d_data",  m_data_o, 32'hD);
    step();
    check("mrst_d_alone", WIDTH'(m_valid_o), 32'd0);

    // Random soak.
    for (int n = 0; n < 10000; n++) begin
      s_valid_i = 1'($urandom_range(0, 1));
      s_data_i  = WIDTH'($urandom);
      m_ready_i = 1'($urandom_range(0, 1));
      flush_i   = ($urandom_range(0, 99) == 0);
      step();
    end
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) step();
    check("drain_sb_empty", WIDTH'(exp_q.size()), 32'd0);
    check("drain_count",    WIDTH'(count_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", dir_checks + mon_checks, dir_errors + mon_errors);
    $finish;
  end

endmodule
